// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster sample-iteration stage.
package raster_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    localparam logic [3:0] SS_1X = 4'b1000;
    localparam logic [3:0] SS_2X = 4'b0100;
    localparam logic [3:0] SS_4X = 4'b0010;
    localparam logic [3:0] SS_8X = 4'b0001;

    // Sample pitch in fixed point; an illegal code falls back to one full pixel.
    function automatic int unsigned ss_step(input logic [3:0] sub_sample, input int radix);
        int k;
        case (sub_sample)
            SS_2X:   k = 1;
            SS_4X:   k = 2;
            SS_8X:   k = 3;
            default: k = 0;
        endcase
        return 32'd1 << (radix - k);
    endfunction

endpackage

// File: rtl/bbox_sample_iterator_iter_step.sv
// Next-sample arithmetic for the row-major box walk: advances (x,y) by one step and
// flags whether the current and the advanced positions are the final sample of the box.
module iter_step #(
    parameter int SIGFIG = 24
) (
    input  logic signed [SIGFIG-1:0] x_i,
    input  logic signed [SIGFIG-1:0] y_i,
    input  logic signed [SIGFIG-1:0] step_i,
    input  logic signed [SIGFIG-1:0] ll_x_i,
    input  logic signed [SIGFIG-1:0] ur_x_i,
    input  logic signed [SIGFIG-1:0] ur_y_i,
    output logic signed [SIGFIG-1:0] nx_o,
    output logic signed [SIGFIG-1:0] ny_o,
    output logic                     last_o,
    output logic                     next_last_o
);

    logic signed [SIGFIG-1:0] x_inc;
    logic signed [SIGFIG-1:0] y_inc;
    logic signed [SIGFIG-1:0] nx_inc;
    logic signed [SIGFIG-1:0] ny_inc;

    always_comb begin
        x_inc  = x_i + step_i;
        y_inc  = y_i + step_i;
        last_o = (x_inc > ur_x_i) && (y_inc > ur_y_i);

        if (x_inc <= ur_x_i) begin
            nx_o = x_inc;
            ny_o = y_i;
        end else begin
            nx_o = ll_x_i;
            ny_o = y_inc;
        end

        // Looking one sample ahead lets the FSM leave TEST on the edge that issues the last sample.
        nx_inc      = nx_o + step_i;
        ny_inc      = ny_o + step_i;
        next_last_o = (nx_inc > ur_x_i) && (ny_inc > ur_y_i);
    end

endmodule

// File: rtl/bbox_sample_iterator.sv
// Latches a triangle and its bounding box and issues one sample location per unstalled cycle.
// Define ITER_STATS_EN to add the triCnt_RnnnnU / sampCnt_RnnnnU statistics outputs.
module bbox_sample_iterator
    import raster_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
    input  logic                                   validTri_R13H,
    input  logic [3:0]                             subSample_RnnnnU,
    input  logic                                   stall_R14H,
    output logic                                   halt_RnnnnH,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
    output logic [1:0][SIGFIG-1:0]                 sample_R14S,
    output logic                                   validSamp_R14H
`ifdef ITER_STATS_EN
    ,
    output logic [31:0]                            triCnt_RnnnnU,
    output logic [31:0]                            sampCnt_RnnnnU
`endif
);

    iter_state_t                            state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic signed [SIGFIG-1:0]               ll_x_q, ll_x_d;
    logic signed [SIGFIG-1:0]               ur_x_q, ur_x_d;
    logic signed [SIGFIG-1:0]               ur_y_q, ur_y_d;
    logic signed [SIGFIG-1:0]               step_q, step_d;
    logic [1:0][SIGFIG-1:0]                 sample_q, sample_d;
    logic                                   valid_q, valid_d;
`ifdef ITER_STATS_EN
    logic [31:0]                            tri_cnt_q, tri_cnt_d;
    logic [31:0]                            samp_cnt_q, samp_cnt_d;
`endif

    logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y, in_step;
    logic                     in_inverted;
    logic signed [SIGFIG-1:0] it_x, it_y, it_step, it_ll_x, it_ur_x, it_ur_y;
    logic signed [SIGFIG-1:0] it_nx, it_ny;
    logic                     it_last, it_next_last;

    always_comb begin
        in_ll_x     = $signed(box_R13S[0][0]);
        in_ll_y     = $signed(box_R13S[0][1]);
        in_ur_x     = $signed(box_R13S[1][0]);
        in_ur_y     = $signed(box_R13S[1][1]);
        in_step     = SIGFIG'(ss_step(subSample_RnnnnU, RADIX));
        in_inverted = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);
    end

    // In WAIT the step logic looks at the incoming box so the accept edge knows if lower-left is final.
    always_comb begin
        if (state_q == TEST) begin
            it_x    = $signed(sample_q[0]);
            it_y    = $signed(sample_q[1]);
            it_step = step_q;
            it_ll_x = ll_x_q;
            it_ur_x = ur_x_q;
            it_ur_y = ur_y_q;
        end else begin
            it_x    = in_ll_x;
            it_y    = in_ll_y;
            it_step = in_step;
            it_ll_x = in_ll_x;
            it_ur_x = in_ur_x;
            it_ur_y = in_ur_y;
        end
    end

    iter_step #(
        .SIGFIG (SIGFIG)
    ) u_iter_step (
        .x_i         (it_x),
        .y_i         (it_y),
        .step_i      (it_step),
        .ll_x_i      (it_ll_x),
        .ur_x_i      (it_ur_x),
        .ur_y_i      (it_ur_y),
        .nx_o        (it_nx),
        .ny_o        (it_ny),
        .last_o      (it_last),
        .next_last_o (it_next_last)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a value unassigned (no latches).
        state_d    = state_q;
        tri_d      = tri_q;
        color_d    = color_q;
        ll_x_d     = ll_x_q;
        ur_x_d     = ur_x_q;
        ur_y_d     = ur_y_q;
        step_d     = step_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
`ifdef ITER_STATS_EN
        tri_cnt_d  = tri_cnt_q;
        samp_cnt_d = samp_cnt_q;
`endif

        if (!stall_R14H) begin
            case (state_q)
                WAIT: begin
                    if (validTri_R13H) begin
                        tri_d    = tri_R13S;
                        color_d  = color_R13U;
                        ll_x_d   = in_ll_x;
                        ur_x_d   = in_ur_x;
                        ur_y_d   = in_ur_y;
                        step_d   = in_step;
                        sample_d = {in_ll_y, in_ll_x};
                        valid_d  = !in_inverted;
                        state_d  = (in_inverted || it_last) ? WAIT : TEST;
`ifdef ITER_STATS_EN
                        tri_cnt_d = tri_cnt_q + 32'd1;
                        if (!in_inverted) begin
                            samp_cnt_d = samp_cnt_q + 32'd1;
                        end
`endif
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                TEST: begin
                    sample_d = {it_ny, it_nx};
                    valid_d  = 1'b1;
                    state_d  = it_next_last ? WAIT : TEST;
`ifdef ITER_STATS_EN
                    samp_cnt_d = samp_cnt_q + 32'd1;
`endif
                end
                default: state_d = WAIT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT;
            tri_q      <= '0;
            color_q    <= '0;
            ll_x_q     <= '0;
            ur_x_q     <= '0;
            ur_y_q     <= '0;
            step_q     <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
`ifdef ITER_STATS_EN
            tri_cnt_q  <= '0;
            samp_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            tri_q      <= tri_d;
            color_q    <= color_d;
            ll_x_q     <= ll_x_d;
            ur_x_q     <= ur_x_d;
            ur_y_q     <= ur_y_d;
            step_q     <= step_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
`ifdef ITER_STATS_EN
            tri_cnt_q  <= tri_cnt_d;
            samp_cnt_q <= samp_cnt_d;
`endif
        end
    end

    assign halt_RnnnnH    = (state_q == TEST);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;
`ifdef ITER_STATS_EN
    assign triCnt_RnnnnU  = tri_cnt_q;
    assign sampCnt_RnnnnU = samp_cnt_q;
`endif

endmodule

// File: tb/tb_bbox_sample_iterator.sv
// Self-checking bench for bbox_sample_iterator: directed cases plus randomized boxes checked
// against a row-major sample list built directly from the box, pitch and stall pattern.
module tb_bbox_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    logic                                   clk = 1'b0;
    logic                                   rst;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in, tri_out;
    logic [COLORS-1:0][SIGFIG-1:0]          color_in, color_out;
    logic [1:0][1:0][SIGFIG-1:0]            box_in;
    logic                                   valid_tri;
    logic [3:0]                             sub_sample;
    logic                                   stall;
    logic                                   halt;
    logic [1:0][SIGFIG-1:0]                 sample_out;
    logic                                   valid_samp;
`ifdef ITER_STATS_EN
    logic [31:0]                            tri_cnt, samp_cnt;
`endif

    typedef struct {
        int x;
        int y;
    } pt_t;

    pt_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_tri = 0;
    int  exp_samp = 0;

    bbox_sample_iterator #(
        .SIGFIG (SIGFIG),
        .RADIX  (RADIX),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub_sample),
        .stall_R14H       (stall),
        .halt_RnnnnH      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample_out),
        .validSamp_R14H   (valid_samp)
`ifdef ITER_STATS_EN
        ,
        .triCnt_RnnnnU    (tri_cnt),
        .sampCnt_RnnnnU   (samp_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference walk: every grid point of the box, rows bottom to top, left to right.
    function automatic void build(input int llx, input int lly, input int urx, input int ury, input int step);
        exp_q.delete();
        for (int y = lly; y <= ury; y += step) begin
            for (int x = llx; x <= urx; x += step) begin
                exp_q.push_back('{x: x, y: y});
            end
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " tri"}, tri_out, '0);
        chk({tag, " color"}, color_out, '0);
        chk({tag, " sample"}, sample_out, '0);
        chk({tag, " valid"}, valid_samp, 1'b0);
        chk({tag, " halt"}, halt, 1'b0);
    endtask

    task automatic chk_stats(input string tag);
`ifdef ITER_STATS_EN
        chk({tag, " triCnt"}, tri_cnt, 32'(exp_tri));
        chk({tag, " sampCnt"}, samp_cnt, 32'(exp_samp));
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic load_tri(input int llx, input int lly, input int urx, input int ury, input int k);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_in[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_in[c] = SIGFIG'($urandom);
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        sub_sample   = 4'b1000 >> k;
    endtask

    // mode: 0 no stall, 1 random stall, 2 three stall cycles while the 2nd sample is shown.
    // abort_idx >= 0 pulses rst while that sample is on the outputs.
    task automatic run_box(input string name, input int llx, input int lly, input int urx, input int ury,
                           input int k, input int mode, input int abort_idx);
        int idx, n, cyc, held;
        logic s;
        logic [SIGFIG-1:0] ex, ey;
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_exp;
        logic [COLORS-1:0][SIGFIG-1:0] color_exp;
        build(llx, lly, urx, ury, 1024 >> k);
        n = exp_q.size();
        @(negedge clk);
        load_tri(llx, lly, urx, ury, k);
        tri_exp   = tri_in;
        color_exp = color_in;
        valid_tri = 1'b1;
        stall     = 1'b0;
        @(negedge clk);
        valid_tri = 1'b0;
        exp_tri++;
        if (n == 0) begin
            chk({name, " inverted valid"}, valid_samp, 1'b0);
            chk({name, " inverted halt"}, halt, 1'b0);
            chk_stats(name);
            return;
        end
        chk({name, " tri"}, tri_out, tri_exp);
        chk({name, " color"}, color_out, color_exp);
        idx  = 0;
        cyc  = 0;
        held = 0;
        while (idx < n && cyc < 5000) begin
            ex = exp_q[idx].x[SIGFIG-1:0];
            ey = exp_q[idx].y[SIGFIG-1:0];
            chk($sformatf("%s x[%0d]", name, idx), sample_out[0], ex);
            chk($sformatf("%s y[%0d]", name, idx), sample_out[1], ey);
            chk($sformatf("%s valid[%0d]", name, idx), valid_samp, 1'b1);
            chk($sformatf("%s halt[%0d]", name, idx), halt, idx < n - 1);
            if (idx == abort_idx) begin
                exp_samp += idx + 1;
                chk_stats({name, " pre-rst"});
                #2 rst = 1'b1;
                #1 chk_zero({name, " async rst"});
                exp_tri  = 0;
                exp_samp = 0;
                @(negedge clk);
                chk_zero({name, " held rst"});
                rst = 1'b0;
                return;
            end
            case (mode)
                1:       s = ($urandom_range(0, 3) == 0);
                2:       s = (idx == 1) && (held < 3);
                default: s = 1'b0;
            endcase
            if (s) held++;
            stall = s;
            @(negedge clk);
            cyc++;
            if (!s) idx++;
        end
        stall = 1'b0;
        chk({name, " cycle budget"}, cyc < 5000, 1'b1);
        chk({name, " end valid"}, valid_samp, 1'b0);
        chk({name, " end halt"}, halt, 1'b0);
        exp_samp += n;
        chk_stats(name);
    endtask

    initial begin
        logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] prev_tri;
        int k, step, llx, lly, urx, ury;

        rst        = 1'b1;
        valid_tri  = 1'b0;
        stall      = 1'b0;
        sub_sample = 4'b1000;
        tri_in     = '0;
        color_in   = '0;
        box_in     = '0;
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // 1x pitch 2x2 box, then the same with a stall after the 2nd sample.
        run_box("px1", 0, 0, 1024, 1024, 0, 0, -1);
        run_box("stall", 0, 0, 1024, 1024, 0, 2, -1);
        // Asynchronous reset while the box is mid-walk.
        run_box("rst_mid", 0, 0, 1024, 1024, 0, 0, 1);
        // Half-pixel pitch: 9 samples; counters reflect this triangle alone.
        run_box("px2", 0, 0, 1024, 1024, 1, 0, -1);
        // Reset during the 3rd sample, then a fresh triangle.
        run_box("px2_abort", 0, 0, 1024, 1024, 1, 0, 2);
        run_box("after_rst", -2048, 1024, 0, 2048, 2, 0, -1);
        run_box("inverted", 1024, 0, 0, 1024, 0, 0, -1);

        // Degenerate box held valid for 3 cycles: three back-to-back single samples, no halt.
        @(negedge clk);
        valid_tri = 1'b1;
        load_tri(2048, 3072, 2048, 3072, 0);
        for (int i = 0; i < 3; i++) begin
            prev_tri = tri_in;
            @(negedge clk);
            exp_tri++;
            exp_samp++;
            chk($sformatf("degen tri[%0d]", i), tri_out, prev_tri);
            chk($sformatf("degen x[%0d]", i), sample_out[0], SIGFIG'(2048));
            chk($sformatf("degen y[%0d]", i), sample_out[1], SIGFIG'(3072));
            chk($sformatf("degen valid[%0d]", i), valid_samp, 1'b1);
            chk($sformatf("degen halt[%0d]", i), halt, 1'b0);
            if (i < 2) load_tri(2048, 3072, 2048, 3072, 0);
        end
        valid_tri = 1'b0;
        @(negedge clk);
        chk("degen end valid", valid_samp, 1'b0);
        chk_stats("degen");

        // Randomized boxes with random pitch, signed corners, random stall.
        for (int r = 0; r < 20; r++) begin
            k    = int'($urandom_range(0, 3));
            step = 1024 >> k;
            llx  = step * (int'($urandom_range(0, 16)) - 8);
            lly  = step * (int'($urandom_range(0, 16)) - 8);
            urx  = llx + step * int'($urandom_range(0, 6));
            ury  = lly + step * int'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) urx = llx - step;
            run_box($sformatf("rand%0d", r), llx, lly, urx, ury, k, 1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
